strhw_add512: RTL and testbench

- Sequential 512-bit modular adder: result = (a + b) mod 2^512, the ring addition used by the Streebog (GOST 34.11-2018) hash.
- Used by the compression-stage controller to update the bit counter N (N + 512, or N + 8*len) and the checksum Sigma (Sigma + block).
- Processes the sum in fixed-width chunks over several cycles to keep the carry chain short.
- Uses a single-pulse trigger / ready-level handshake.

---
 rtl/strhw_add512.sv | 81 ++++++++
 tb/tb_strhw_add512.sv | 103 ++++++++++
 2 files changed

// File: rtl/strhw_add512.sv
// strhw_add512: multi-cycle 512-bit modular adder (a + b mod 2^512), CHUNK_W bits per cycle
module strhw_add512 #(
    parameter int CHUNK_W = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         trg_i,
    input  logic [511:0] a_i,
    input  logic [511:0] b_i,
    output logic [511:0] result_o,
    output logic         ready_o
);
    localparam int NCHUNK = 512 / CHUNK_W;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic [511:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
    logic           carry_q, carry_d, ready_q, ready_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [CHUNK_W:0] sum_w;

    assign sum_w = {1'b0, a_q[idx_q*CHUNK_W +: CHUNK_W]} + {1'b0, b_q[idx_q*CHUNK_W +: CHUNK_W]}
                 + {{CHUNK_W{1'b0}}, carry_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        ready_d  = ready_q;
        if (trg_i) begin
            state_d = BUSY;
            a_d     = a_i;
            b_d     = b_i;
            acc_d   = '0;
            carry_d = 1'b0;
            idx_d   = '0;
            ready_d = 1'b0;
        end else if (state_q == BUSY) begin
            acc_d[idx_q*CHUNK_W +: CHUNK_W] = sum_w[CHUNK_W-1:0];
            carry_d = sum_w[CHUNK_W];
            idx_d   = idx_q + IW'(1);
            // final chunk: publish the whole sum at once, top carry dropped
            if (idx_q == IW'(NCHUNK - 1)) begin
                result_d = acc_d;
                ready_d  = 1'b1;
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
endmodule

// File: tb/tb_strhw_add512.sv
// tb_strhw_add512: checks three chunk widths against a plain 512-bit arithmetic model
module tb_strhw_add512;
    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         trg_i = 1'b0;
    logic [511:0] a_i = '0, b_i = '0;
    logic [511:0] res [3];
    logic         rdy [3];
    logic [511:0] prev [3];
    int           lat [3] = '{8, 16, 1};
    int           n_assert = 0, n_fail = 0;

    always #5 clk = ~clk;

    strhw_add512 #(.CHUNK_W(64)) u64 (.clk_i(clk), .rst_i(rst_i), .trg_i(trg_i), .a_i(a_i), .b_i(b_i),
                                      .result_o(res[0]), .ready_o(rdy[0]));
    strhw_add512 #(.CHUNK_W(32)) u32 (.clk_i(clk), .rst_i(rst_i), .trg_i(trg_i), .a_i(a_i), .b_i(b_i),
                                      .result_o(res[1]), .ready_o(rdy[1]));
    strhw_add512 #(.CHUNK_W(512)) u512 (.clk_i(clk), .rst_i(rst_i), .trg_i(trg_i), .a_i(a_i), .b_i(b_i),
                                        .result_o(res[2]), .ready_o(rdy[2]));

    task automatic chk(input string tag, input logic [511:0] o, input logic [511:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s obs=%h exp=%h", tag, o, e);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        case ($urandom_range(0, 5))
            0: r = '1;
            1: r = 512'(1) << $urandom_range(0, 511);
            2: r = '0;
            default: ;
        endcase
        return r;
    endfunction

    task automatic check_all(input string tag, input logic e_rdy [3], input logic [511:0] e_res [3]);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("%s ready[%0d]", tag, j), {511'd0, rdy[j]}, {511'd0, e_rdy[j]});
            chk($sformatf("%s result[%0d]", tag, j), res[j], e_res[j]);
        end
    endtask

    // one-cycle trigger, then watch n edges; operands are scrambled while busy
    task automatic go(input logic [511:0] a, input logic [511:0] b, input int n);
        logic [511:0] s;
        logic         er [3];
        logic [511:0] ev [3];
        s = a + b;
        @(negedge clk);
        a_i = a; b_i = b; trg_i = 1'b1;
        @(posedge clk); #1;
        trg_i = 1'b0; a_i = rnd512(); b_i = rnd512();
        for (int j = 0; j < 3; j++) begin er[j] = 1'b0; ev[j] = prev[j]; end
        check_all("trig", er, ev);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 3; j++) begin
                er[j] = (k >= lat[j]);
                ev[j] = (k >= lat[j]) ? s : prev[j];
            end
            check_all($sformatf("edge%0d", k), er, ev);
        end
        for (int j = 0; j < 3; j++) if (n >= lat[j]) prev[j] = s;
    endtask

    initial begin
        logic         z [3];
        logic [511:0] zv [3];
        for (int j = 0; j < 3; j++) begin prev[j] = '0; z[j] = 1'b0; zv[j] = '0; end
        #1 check_all("in_reset", z, zv);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_i = 1'b1;
        repeat (5) begin @(posedge clk); #1 check_all("idle", z, zv); end

        go(512'd0, 512'd512, 16);
        go('1, 512'd1, 16);
        go({448'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 512'd1, 16);
        go(512'd5, 512'd7, 16);
        go(512'd1, 512'd1, 3);
        go(512'd10, 512'd20, 16);

        @(negedge clk);
        a_i = 512'd99; b_i = 512'd1; trg_i = 1'b1;
        @(posedge clk); #1 trg_i = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_i = 1'b0;
        #1 check_all("async_rst", z, zv);
        @(negedge clk) rst_i = 1'b1;
        repeat (20) begin @(posedge clk); #1 check_all("after_rst", z, zv); end
        for (int j = 0; j < 3; j++) prev[j] = '0;

        for (int i = 0; i < 1000; i++) go(rnd512(), rnd512(), 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
